mmu_seq_ctrl: RTL
=================

Name: mmu_seq_ctrl

Overview:
- Sequencer that drives the DEPTH x DEPTH systolic MMU through one job: weight preload, skewed activation streaming, drain, and result capture.
- Sits between the weight/activation buffers (valid/ready sources) and the MMU's control/data_arr/wt_arr/acc_out pins.
- Emits one de-skewed result vector per fed activation vector.

Parameters:
- DEPTH, 4, array rows/cols and number of weight beats per job.
- BIT_WIDTH, 8, element width of weights and activations.
- ACC_WIDTH, 32, accumulator lane width.
- CNT_W, 8, width of the vector count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  job start pulse; sampled in IDLE only.
- num_vecs  in  CNT_W  activation vectors in the job; latched on start.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse when the job completes.
- wt_valid / wt_ready  in / out  1  weight-row handshake.
- wt_data  in  BIT_WIDTH*DEPTH  one weight row per beat.
- act_valid / act_ready  in / out  1  activation-vector handshake.
- act_data  in  BIT_WIDTH*DEPTH  one activation vector per beat; lane i is bits [8i+7:8i].
- mmu_control  out  1  to MMU control; 1 = weight shift.
- mmu_wt_arr  out  BIT_WIDTH*DEPTH  to MMU wt_arr.
- mmu_data_arr  out  BIT_WIDTH*DEPTH  to MMU data_arr, skewed.
- mmu_acc_out  in  ACC_WIDTH*DEPTH  from MMU acc_out.
- res_valid  out  1  result strobe; no backpressure.
- res_data  out  ACC_WIDTH*DEPTH  registered copy of mmu_acc_out on each strobe.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - Counters, token shift register and skew registers clear.
  - Outputs go to 0: busy, done, wt_ready, act_ready, mmu_control, mmu_wt_arr, mmu_data_arr, res_valid and res_data.
  - A reset mid-job abandons the job; no done pulse is issued.
- IDLE: start=1 latches num_vecs and moves to LOAD_WT. start while busy is ignored.
- LOAD_WT:
  - wt_ready=1.
  - On a wt_valid&wt_ready beat, the controller drives mmu_control=1 and mmu_wt_arr=wt_data for that cycle, and wt_cnt increments.
  - On a bubble (wt_valid=0), it drives mmu_control=0 and all-zero buses, so the MMU holds its weights.
  - After DEPTH beats, go to FEED, or straight to DONE if num_vecs=0.
- FEED:
  - act_ready=1 and mmu_control=0.
  - On an accepted beat, lane i of act_data enters a skew line of i register stages. Lane 0 is unskewed; lane DEPTH-1 is delayed DEPTH-1 cycles.
  - On a bubble, zeros enter the skew lines.
  - A token bit (1 on accepted beat, 0 on bubble) enters a LAT-deep shift register, with LAT = 2*DEPTH.
  - After num_vecs accepted beats, deassert act_ready and go to DRAIN.
- DRAIN:
  - Zeros are fed and tokens keep shifting.
  - Exit to DONE when the token register is all-zero and at least LAT cycles have passed since the last accepted beat.
- Result capture: when the token register's output bit is 1, register res_data <= mmu_acc_out and set res_valid=1 for one cycle. This gives exactly LAT cycles from an accepted act beat to its res_valid.
- DONE: done=1 for one cycle, busy drops in the same cycle, then return to IDLE. A start in the DONE cycle is ignored.
- Counters:
  - vec_cnt is CNT_W bits and saturates at num_vecs; there is no wrap.
  - wt_cnt is clog2(DEPTH)+1 bits.
- Result order equals acceptance order.
- Total results per job = num_vecs.

Optional Feature:
- Macro MMU_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts LOAD_WT/FEED cycles where the ready was high but the valid was low.
  - Both clear on accepted start and on reset, saturate at all-ones, and hold after DONE.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-FEED (num_vecs=5, 2 vectors accepted) -> after the reset edge, state is IDLE, busy=0, no res_valid follows, no done pulse.
- All-ones weights; num_vecs=1, act lanes {1,2,3,4}, no bubbles -> mmu_control high exactly 4 cycles; res_valid 8 cycles after the act beat; every res_data lane = 10; done follows.
- Weight bubbles: wt_valid pattern 1,0,1,1,0,1 -> mmu_control pulses exactly on the 4 valid beats, mmu_wt_arr=0 on bubbles, FEED entered after the 4th beat.
- num_vecs=3 with act_valid gaps 1,0,0,1,1 -> 3 res_valid strobes spaced 3,1 cycles apart (gaps preserved), results in order, done once.
- num_vecs=0 -> after 4 weight beats, done pulses; act_ready never asserts; zero res_valid.
- start asserted while busy and in the DONE cycle -> ignored; num_vecs latch unchanged. With MMU_SEQ_PERF_EN, perf_stalls equals the injected bubble count (e.g. 4).

Source files
------------

// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl: single-job sequencer for a DEPTH x DEPTH systolic MMU.
// It loads DEPTH weight rows, streams skewed activation vectors, drains the
// array, and captures one result vector per accepted activation vector.
// Optional performance counters are enabled by defining MMU_SEQ_PERF_EN.
module mmu_seq_ctrl #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [CNT_W-1:0]               num_vecs,
    output logic                           busy,
    output logic                           done,
    input  logic                           wt_valid,
    output logic                           wt_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]     wt_data,
    input  logic                           act_valid,
    output logic                           act_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]     act_data,
    output logic                           mmu_control,
    output logic [BIT_WIDTH*DEPTH-1:0]     mmu_wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]     mmu_data_arr,
    input  logic [ACC_WIDTH*DEPTH-1:0]     mmu_acc_out,
    output logic                           res_valid,
    output logic [ACC_WIDTH*DEPTH-1:0]     res_data
`ifdef MMU_SEQ_PERF_EN
   ,output logic [31:0]                    perf_cycles,
    output logic [31:0]                    perf_stalls
`endif
);

    localparam int LAT     = 2 * DEPTH;
    localparam int WT_W    = $clog2(DEPTH) + 1;
    localparam int SINCE_W = $clog2(LAT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_WT,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [CNT_W-1:0]           vec_total;
    logic [CNT_W-1:0]           vec_cnt;
    logic [WT_W-1:0]            wt_cnt;
    // Token line: LAT-1 internal stages, with res_valid acting as the final
    // stage so an accepted beat strobes res_valid exactly LAT cycles later.
    logic [LAT-2:0]             tok;
    logic [SINCE_W-1:0]         since;
    logic                       start_acc;
    logic                       wt_beat;
    logic                       act_beat;
    logic                       last_wt;
    logic                       last_act;
    logic [BIT_WIDTH*DEPTH-1:0] skew_in;
    logic [BIT_WIDTH-1:0]       lane_out [DEPTH];

    assign start_acc = (state == ST_IDLE) && start;
    assign wt_beat   = (state == ST_LOAD_WT) && wt_valid;
    assign act_beat  = (state == ST_FEED) && act_valid;
    assign last_wt   = wt_beat && (wt_cnt == WT_W'(DEPTH - 1));
    assign last_act  = act_beat && ((vec_cnt + CNT_W'(1)) == vec_total);
    assign skew_in   = act_beat ? act_data : '0;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_LOAD_WT;
            ST_LOAD_WT: if (last_wt) state_nxt = (vec_total == '0) ? ST_DONE : ST_FEED;
            ST_FEED:    if (last_act) state_nxt = ST_DRAIN;
            ST_DRAIN:   if ((tok == '0) && (since >= SINCE_W'(LAT))) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and MMU control outputs decoded from state
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        wt_ready    = 1'b0;
        act_ready   = 1'b0;
        mmu_control = 1'b0;
        mmu_wt_arr  = '0;
        unique case (state)
            ST_LOAD_WT: begin
                busy     = 1'b1;
                wt_ready = 1'b1;
                if (wt_valid) begin
                    mmu_control = 1'b1;
                    mmu_wt_arr  = wt_data;
                end
            end
            ST_FEED: begin
                busy      = 1'b1;
                act_ready = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // State, counters, token line and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec_total <= '0;
            vec_cnt   <= '0;
            wt_cnt    <= '0;
            tok       <= '0;
            since     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nxt;
            tok       <= {tok[LAT-3:0], act_beat};
            res_valid <= tok[LAT-2];
            if (tok[LAT-2]) res_data <= mmu_acc_out;

            if (start_acc) begin
                vec_total <= num_vecs;
                vec_cnt   <= '0;
                wt_cnt    <= '0;
                since     <= '0;
            end else begin
                if (wt_beat) wt_cnt <= wt_cnt + WT_W'(1);
                if (act_beat && (vec_cnt != vec_total)) vec_cnt <= vec_cnt + CNT_W'(1);
                if (act_beat) since <= SINCE_W'(1);
                else if (since < SINCE_W'(LAT)) since <= since + SINCE_W'(1);
            end
        end
    end

    // Lane 0 passes straight through; lane i is delayed by i register stages
    assign lane_out[0] = skew_in[BIT_WIDTH-1:0];

    for (genvar i = 1; i < DEPTH; i++) begin : g_skew
        logic [BIT_WIDTH-1:0] line [i];

        // Skew line for lane i
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                line <= '{default: '0};
            end else begin
                line[0] <= skew_in[i*BIT_WIDTH +: BIT_WIDTH];
                for (int unsigned k = 1; k < unsigned'(i); k++) line[k] <= line[k-1];
            end
        end

        assign lane_out[i] = line[i-1];
    end

    // Pack skewed lanes onto the MMU data bus
    always_comb begin
        mmu_data_arr = '0;
        for (int unsigned l = 0; l < unsigned'(DEPTH); l++)
            mmu_data_arr[l*BIT_WIDTH +: BIT_WIDTH] = lane_out[l];
    end

`ifdef MMU_SEQ_PERF_EN
    logic stall;
    assign stall = ((state == ST_LOAD_WT) && !wt_valid) || ((state == ST_FEED) && !act_valid);

    // Saturating busy-cycle and stall counters, cleared per job
    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if (stall && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
